// File: rtl/mem_cache_ctrl_if.sv
// MEM-stage request/response plus SRAM-side signals of the data cache.
// The slave modport is the cache; master is the pipeline/SRAM environment.
interface mem_cache_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        r_en;
  logic        w_en;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output addr, wdata, r_en, w_en, sram_rdata, sram_ready,
    input  rdata, ready, sram_addr, sram_wdata, sram_r_en, sram_w_en
  );

  modport slave (
    input  addr, wdata, r_en, w_en, sram_rdata, sram_ready,
    output rdata, ready, sram_addr, sram_wdata, sram_r_en, sram_w_en
  );
endinterface

// File: rtl/mem_cache_ctrl.sv
// 2-way write-through, no-write-allocate data cache; read hits complete in 0 waits.
// Misses and all stores hold ready low until the SRAM reports sram_ready.
module mem_cache_ctrl #(
  parameter int          SETS  = 64,
  parameter int          TAG_W = 10,
  parameter logic [31:0] BASE  = 32'd1024
) (
  input logic             clk,
  input logic             rst,
  mem_cache_ctrl_if.slave bus
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 3 + IDX_W;

  typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

  state_t state;
  state_t next_state;
  state_t cur;

  logic [31:0]      eff;
  logic             offset;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;

  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [63:0]      data_q  [2][SETS];

  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  logic        victim;
  logic [63:0] hit_block;
  logic [31:0] hit_word;
  logic [31:0] fill_word;

  assign eff              = bus.addr - BASE;
  assign offset           = eff[2];
  assign idx              = eff[3 +: IDX_W];
  assign tag              = eff[TAG_LSB +: TAG_W];
  assign unused_addr_bits = ^{eff[1:0], eff[31:TAG_LSB+TAG_W]};

  assign hit0      = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1      = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1;
  assign hit_block = hit_way ? data_q[1][idx] : data_q[0][idx];
  assign hit_word  = offset ? hit_block[63:32] : hit_block[31:0];
  assign fill_word = offset ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];

  // Prefer an empty way before consulting lru.
  assign victim = !valid_q[0][idx] ? 1'b0 :
                  !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  // Outputs look idle while reset is asserted, so an in-flight SRAM access drops at once.
  assign cur = rst ? state : IDLE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.w_en) begin
          next_state = WRITE;
        end else if (bus.r_en && !hit) begin
          next_state = RMISS;
        end
      end
      RMISS:   if (bus.sram_ready) next_state = IDLE;
      WRITE:   if (bus.sram_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ready      = 1'b1;
    bus.rdata      = '0;
    bus.sram_r_en  = 1'b0;
    bus.sram_w_en  = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    case (cur)
      IDLE: begin
        if (bus.w_en) begin
          bus.ready = 1'b0;
        end else if (bus.r_en) begin
          if (hit) begin
            bus.rdata = hit_word;
          end else begin
            bus.ready = 1'b0;
          end
        end
      end
      RMISS: begin
        bus.sram_r_en = 1'b1;
        bus.sram_addr = {eff[31:3], 3'b000};
        bus.ready     = bus.sram_ready;
        if (bus.sram_ready) begin
          bus.rdata = fill_word;
        end
      end
      WRITE: begin
        bus.sram_w_en  = 1'b1;
        bus.sram_addr  = eff;
        bus.sram_wdata = bus.wdata;
        bus.ready      = bus.sram_ready;
      end
      default: bus.ready = 1'b1;
    endcase
  end

  // A store to a cached line invalidates it rather than updating it in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.w_en) begin
            if (hit0) valid_q[0][idx] <= 1'b0;
            if (hit1) valid_q[1][idx] <= 1'b0;
          end else if (bus.r_en && hit) begin
            lru_q[idx] <= ~hit_way;
          end
        end
        RMISS: begin
          if (bus.sram_ready) begin
            valid_q[victim][idx] <= 1'b1;
            lru_q[idx]           <= ~victim;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && (state == RMISS) && bus.sram_ready) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= bus.sram_rdata;
    end
  end

endmodule
